// File: rtl/loop_down_counter_if.sv
// Handshake bundle for loop_down_counter: start/init_val/hold in, status and count out.
// master drives the controls; slave is the counter itself.
interface loop_down_counter_if #(
   parameter int unsigned WIDTH = 4
);
   logic             start;
   logic [WIDTH-1:0] init_val;
   logic             hold;
   logic             busy;
   logic             tick;
   logic             done;
   logic [WIDTH-1:0] count;
   logic             zero;

   modport master (
      output start, init_val, hold,
      input  busy, tick, done, count, zero
   );

   modport slave (
      input  start, init_val, hold,
      output busy, tick, done, count, zero
   );
endinterface

// File: rtl/loop_down_counter.sv
// Loadable down-counter with start/done handshake: loads init_val on start, issues one tick
// per un-held RUN cycle until the count reaches zero, then pulses done for one cycle.
module loop_down_counter #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   loop_down_counter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] count_q;
   logic             busy_q;
   logic             done_q;

   logic             cnt_zero;
   logic             cnt_last;
   logic             init_zero;
   logic             run_step;

   // Nor/Or gate-layer primitives used for the zero detect and next-state gating.
   function automatic logic c1_nor(input logic [WIDTH-1:0] v);
      return ~(|v);
   endfunction

   function automatic logic c1_or2(input logic a, input logic b);
      return a | b;
   endfunction

   assign cnt_zero  = c1_nor(count_q);
   // count==1: bit 0 set and every upper bit clear.
   assign cnt_last  = count_q[0] & c1_nor({1'b0, count_q[WIDTH-1:1]});
   assign init_zero = c1_nor(bus.init_val);
   // A RUN cycle advances only when not held; a zero count never decrements.
   assign run_step  = ~c1_or2(bus.hold, cnt_zero);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         count_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  count_q <= bus.init_val;
                  if (init_zero) begin
                     state  <= DONE;
                     busy_q <= 1'b0;
                     done_q <= 1'b1;
                  end else begin
                     state  <= RUN;
                     busy_q <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (run_step) begin
                  count_q <= count_q - WIDTH'(1);
                  if (cnt_last) begin
                     state  <= DONE;
                     busy_q <= 1'b0;
                     done_q <= 1'b1;
                  end
               end
            end
            DONE: begin
               state  <= IDLE;
               busy_q <= 1'b0;
               done_q <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
               done_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.count = count_q;
   assign bus.zero  = cnt_zero;
   assign bus.tick  = busy_q & ~bus.hold;

endmodule

// File: tb/tb_loop_down_counter.sv
// Directed self-checking bench for loop_down_counter (WIDTH=4).
module tb_loop_down_counter;

   localparam int unsigned WIDTH = 4;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   loop_down_counter_if #(.WIDTH(WIDTH)) bus ();

   loop_down_counter #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      rst_n = 1'b0;
      bus.start = 1'b0;
      bus.init_val = '0;
      bus.hold = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus.count !== 4'd0 || bus.zero !== 1'b1 || bus.busy !== 1'b0 ||
          bus.done !== 1'b0 || bus.tick !== 1'b0) begin
         failures++;
         $display("FAIL reset_in: count=%0d zero=%b busy=%b done=%b tick=%b required 0 1 0 0 0",
                  bus.count, bus.zero, bus.busy, bus.done, bus.tick);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.count !== 4'd0 || bus.zero !== 1'b1 || bus.busy !== 1'b0 ||
          bus.done !== 1'b0 || bus.tick !== 1'b0) begin
         failures++;
         $display("FAIL reset_idle: count=%0d zero=%b busy=%b done=%b tick=%b required 0 1 0 0 0",
                  bus.count, bus.zero, bus.busy, bus.done, bus.tick);
      end
   endtask

   task automatic test_count5();
      int ticks;
      ticks = 0;
      bus.init_val = 4'd5;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (bus.busy !== 1'b1 || bus.tick !== 1'b1 || bus.count !== 4'(5 - i) ||
             bus.done !== 1'b0) begin
            failures++;
            $display("FAIL count5_run[%0d]: busy=%b tick=%b count=%0d done=%b required 1 1 %0d 0",
                     i, bus.busy, bus.tick, bus.count, bus.done, 5 - i);
         end
         if (bus.tick === 1'b1) ticks++;
         @(negedge clk);
      end
      checks++;
      if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.tick !== 1'b0 ||
          bus.count !== 4'd0 || bus.zero !== 1'b1) begin
         failures++;
         $display("FAIL count5_done: done=%b busy=%b tick=%b count=%0d zero=%b required 1 0 0 0 1",
                  bus.done, bus.busy, bus.tick, bus.count, bus.zero);
      end
      checks++;
      if (ticks != 5) begin
         failures++;
         $display("FAIL count5_ticks: got %0d required 5", ticks);
      end
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.count !== 4'd0) begin
         failures++;
         $display("FAIL count5_idle: done=%b busy=%b count=%0d required 0 0 0",
                  bus.done, bus.busy, bus.count);
      end
   endtask

   task automatic test_zero_init();
      bus.init_val = 4'd0;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      checks++;
      if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.tick !== 1'b0 || bus.count !== 4'd0) begin
         failures++;
         $display("FAIL zero_init_done: done=%b busy=%b tick=%b count=%0d required 1 0 0 0",
                  bus.done, bus.busy, bus.tick, bus.count);
      end
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.tick !== 1'b0) begin
         failures++;
         $display("FAIL zero_init_idle: done=%b busy=%b tick=%b required 0 0 0",
                  bus.done, bus.busy, bus.tick);
      end
   endtask

   task automatic test_hold();
      logic [5:0] hold_pat;
      logic [3:0] exp_cnt [6];
      int ticks;
      hold_pat = 6'b000110;  // bit k = hold during RUN cycle k
      exp_cnt = '{4'd4, 4'd3, 4'd3, 4'd3, 4'd2, 4'd1};
      ticks = 0;
      bus.init_val = 4'd4;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int k = 0; k < 6; k++) begin
         bus.hold = hold_pat[k];
         #1;
         checks++;
         if (bus.busy !== 1'b1 || bus.count !== exp_cnt[k] || bus.tick !== ~hold_pat[k] ||
             bus.done !== 1'b0) begin
            failures++;
            $display("FAIL hold_run[%0d]: busy=%b count=%0d tick=%b done=%b required 1 %0d %b 0",
                     k, bus.busy, bus.count, bus.tick, bus.done, exp_cnt[k], ~hold_pat[k]);
         end
         if (bus.tick === 1'b1) ticks++;
         @(negedge clk);
      end
      bus.hold = 1'b0;
      checks++;
      if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.count !== 4'd0) begin
         failures++;
         $display("FAIL hold_done: done=%b busy=%b count=%0d required 1 0 0",
                  bus.done, bus.busy, bus.count);
      end
      checks++;
      if (ticks != 4) begin
         failures++;
         $display("FAIL hold_ticks: got %0d required 4", ticks);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int ticks;
      ticks = 0;
      bus.init_val = 4'd15;
      bus.start = 1'b1;
      @(negedge clk);
      bus.init_val = 4'd3;
      for (int i = 0; i < 15; i++) begin
         bus.start = (i % 2 == 0);
         checks++;
         if (bus.busy !== 1'b1 || bus.tick !== 1'b1 || bus.count !== 4'(15 - i)) begin
            failures++;
            $display("FAIL max_run[%0d]: busy=%b tick=%b count=%0d required 1 1 %0d",
                     i, bus.busy, bus.tick, bus.count, 15 - i);
         end
         if (bus.tick === 1'b1) ticks++;
         @(negedge clk);
      end
      bus.start = 1'b1;
      checks++;
      if (bus.done !== 1'b1 || bus.count !== 4'd0 || ticks != 15) begin
         failures++;
         $display("FAIL max_done: done=%b count=%0d ticks=%0d required 1 0 15",
                  bus.done, bus.count, ticks);
      end
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.count !== 4'd0) begin
         failures++;
         $display("FAIL max_no_reload: busy=%b done=%b count=%0d required 0 0 0",
                  bus.busy, bus.done, bus.count);
      end
      bus.init_val = 4'd2;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      checks++;
      if (bus.busy !== 1'b1 || bus.count !== 4'd2 || bus.tick !== 1'b1) begin
         failures++;
         $display("FAIL b2b_load: busy=%b count=%0d tick=%b required 1 2 1",
                  bus.busy, bus.count, bus.tick);
      end
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b1 || bus.count !== 4'd1) begin
         failures++;
         $display("FAIL b2b_run: busy=%b count=%0d required 1 1", bus.busy, bus.count);
      end
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.count !== 4'd0) begin
         failures++;
         $display("FAIL b2b_done: done=%b busy=%b count=%0d required 1 0 0",
                  bus.done, bus.busy, bus.count);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_abort();
      bus.init_val = 4'd7;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.count !== 4'd4 || bus.busy !== 1'b1) begin
         failures++;
         $display("FAIL abort_pre: count=%0d busy=%b required 4 1", bus.count, bus.busy);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.count !== 4'd0 || bus.busy !== 1'b0 || bus.tick !== 1'b0 ||
          bus.zero !== 1'b1 || bus.done !== 1'b0) begin
         failures++;
         $display("FAIL abort_async: count=%0d busy=%b tick=%b zero=%b done=%b required 0 0 0 1 0",
                  bus.count, bus.busy, bus.tick, bus.zero, bus.done);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_done[%0d]: done=%b busy=%b required 0 0",
                     i, bus.done, bus.busy);
         end
      end
      test_count5();
   endtask

   initial begin
      checks = 0;
      failures = 0;
      rst_n = 1'b0;
      bus.start = 1'b0;
      bus.init_val = '0;
      bus.hold = 1'b0;
      test_reset();
      test_count5();
      test_zero_init();
      test_hold();
      test_back_to_back();
      test_reset_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
